// File: rtl/irq_ctrl_nch.sv
// N-channel interrupt controller: sync, mask, prioritise, deliver to CU64.
// Optional nested preemption via IRQ_CTRL_NESTED_INT_EN.
module irq_ctrl_nch #(
  parameter int          NUM_IRQ    = 8,
  parameter int          ID_W       = 3,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter int          VEC_STRIDE = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [NUM_IRQ-1:0] cfg_wdata,
  output logic [NUM_IRQ-1:0] cfg_rdata,
  output logic               interrupt,
  input  logic               int_ack,
  input  logic               eoi,
  output logic [31:0]        int_vec,
  output logic [ID_W-1:0]    int_id,
  output logic               in_service
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_e;

  state_e state_q, state_d;

  logic [NUM_IRQ-1:0] sync1_q, sirq_q, sprev_q;
  logic [NUM_IRQ-1:0] en_q, en_d;
  logic [NUM_IRQ-1:0] edge_q, edge_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [31:0]        vec_q, vec_d;

  logic [NUM_IRQ-1:0] rise, pend_view, elig;
  logic [NUM_IRQ-1:0] id_oh, w1c, ack_clr, eoi_clr;
  logic [ID_W-1:0]    win_id;
  logic [31:0]        win_vec;
  logic               win_vld;
  logic               ack_fire, eoi_fire;

  assign rise      = sirq_q & ~sprev_q;
  assign pend_view = (edge_q & pend_q) | (~edge_q & sirq_q);
  assign elig      = pend_view & en_q & ~isr_q;
  assign win_vld   = |elig;

  always_comb begin
    win_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) win_id = ID_W'(i);
    end
  end

  assign win_vec = VEC_BASE + 32'(win_id) * 32'(VEC_STRIDE);

  always_comb begin
    id_oh = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      id_oh[i] = (id_q == ID_W'(i));
    end
  end

`ifdef IRQ_CTRL_NESTED_INT_EN
  logic [NUM_IRQ-1:0] isr_low, isr_above;
  logic               preempt;

  // isr_above: every index with higher priority than the active ISR.
  assign isr_low   = isr_q & (~isr_q + NUM_IRQ'(1));
  assign isr_above = isr_low - NUM_IRQ'(1);
  assign preempt   = |(elig & isr_above);
`endif

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    vec_d    = vec_q;
    ack_fire = 1'b0;
    eoi_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          id_d    = win_id;
          vec_d   = win_vec;
          state_d = REQ;
        end
      end
      REQ: begin
        if (int_ack) begin
          ack_fire = 1'b1;
          state_d  = SERVICE;
        end
      end
      SERVICE: begin
`ifdef IRQ_CTRL_NESTED_INT_EN
        if (eoi) begin
          eoi_fire = 1'b1;
          state_d  = |(isr_q & ~isr_low) ? SERVICE : IDLE;
        end else if (preempt) begin
          id_d    = win_id;
          vec_d   = win_vec;
          state_d = REQ;
        end
`else
        if (eoi) begin
          eoi_fire = 1'b1;
          state_d  = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign w1c     = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata : '0;
  assign ack_clr = ack_fire ? id_oh : '0;
`ifdef IRQ_CTRL_NESTED_INT_EN
  assign eoi_clr = eoi_fire ? isr_low : '0;
`else
  assign eoi_clr = eoi_fire ? id_oh : '0;
`endif

  always_comb begin
    en_d   = en_q;
    edge_d = edge_q;
    if (cfg_we && cfg_addr == 2'd0) en_d = cfg_wdata;
    if (cfg_we && cfg_addr == 2'd1) edge_d = cfg_wdata;
    // Edge set wins over W1C or ack clear in the same cycle.
    pend_d = (edge_q & ((pend_q & ~w1c & ~ack_clr) | rise))
           | (~edge_q & sirq_q);
    isr_d  = (isr_q | ack_clr) & ~eoi_clr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sync1_q <= '0;
      sirq_q  <= '0;
      sprev_q <= '0;
      en_q    <= '0;
      edge_q  <= '0;
      pend_q  <= '0;
      isr_q   <= '0;
      id_q    <= '0;
      vec_q   <= VEC_BASE;
    end else begin
      state_q <= state_d;
      sync1_q <= irq;
      sirq_q  <= sync1_q;
      sprev_q <= sirq_q;
      en_q    <= en_d;
      edge_q  <= edge_d;
      pend_q  <= pend_d;
      isr_q   <= isr_d;
      id_q    <= id_d;
      vec_q   <= vec_d;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    unique case (cfg_addr)
      2'd0: cfg_rdata = en_q;
      2'd1: cfg_rdata = edge_q;
      2'd2: cfg_rdata = pend_view;
      2'd3: cfg_rdata = isr_q;
      default: cfg_rdata = '0;
    endcase
  end

  assign interrupt  = (state_q == REQ);
  assign int_id     = id_q;
  assign int_vec    = vec_q;
  assign in_service = |isr_q;

endmodule

// File: tb/tb_irq_ctrl_nch.sv
// Directed and randomized bench for irq_ctrl_nch (8 sources).
// Expected ids come from a priority model over the driven masks.
module tb_irq_ctrl_nch;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic [7:0]  cfg_rdata;
  logic        interrupt;
  logic        int_ack;
  logic        eoi;
  logic [31:0] int_vec;
  logic [2:0]  int_id;
  logic        in_service;

  int checks = 0;
  int errors = 0;

  irq_ctrl_nch dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata),
    .interrupt  (interrupt),
    .int_ack    (int_ack),
    .eoi        (eoi),
    .int_vec    (int_vec),
    .int_id     (int_id),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
    cfg_wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  task automatic wait_int(input string tag);
    int n;
    n = 0;
    while (!interrupt && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(interrupt), 32'd1);
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] vec_of(input int id);
    return 32'h100 + 32'(id) * 32'd8;
  endfunction

  initial begin
    logic [7:0] r;
    logic [7:0] m, e, p;
    int         exp_id;
    int         q[$];

    reset     = 1'b0;
    irq       = '0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    int_ack   = 1'b0;
    eoi       = 1'b0;
    ticks(3);

    chk("rst_int", 32'(interrupt), 0);
    chk("rst_vec", int_vec, 32'h100);
    chk("rst_id", 32'(int_id), 0);
    chk("rst_insvc", 32'(in_service), 0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), r);
      chk($sformatf("rst_reg%0d", a), 32'(r), 0);
    end
    reset = 1'b1;
    tick();

    // level mode latency and delivery of irq[3]
    wr(2'd0, 8'hFF);
    irq[3] = 1'b1;
    ticks(2);
    chk("lat_early", 32'(interrupt), 0);
    tick();
    chk("lat_int", 32'(interrupt), 1);
    chk("lat_id", 32'(int_id), 3);
    chk("lat_vec", int_vec, 32'h118);
    ack();
    chk("ack_int", 32'(interrupt), 0);
    rd(2'd3, r);
    chk("ack_isr", 32'(r), 32'h08);
    chk("ack_insvc", 32'(in_service), 1);
    irq[3] = 1'b0;
    ticks(3);
    do_eoi();
    rd(2'd3, r);
    chk("eoi_isr", 32'(r), 0);
    chk("eoi_insvc", 32'(in_service), 0);
    ticks(2);

    // simultaneous edges, priority order
    wr(2'd1, 8'hFF);
    irq = 8'h24;
    ticks(3);
    irq = 8'h00;
    wait_int("pri_to1");
    chk("pri_id1", 32'(int_id), 2);
    ack();
    do_eoi();
    wait_int("pri_to2");
    chk("pri_id2", 32'(int_id), 5);
    chk("pri_vec2", int_vec, 32'h128);
    ack();
    do_eoi();
    rd(2'd2, r);
    chk("pri_pend", 32'(r), 0);

    // masked pending then enable
    wr(2'd0, 8'hFB);
    irq[2] = 1'b1;
    ticks(3);
    irq[2] = 1'b0;
    ticks(3);
    rd(2'd2, r);
    chk("msk_pend", 32'(r), 32'h04);
    chk("msk_int", 32'(interrupt), 0);
    wr(2'd0, 8'hFF);
    wait_int("msk_to");
    chk("msk_id", 32'(int_id), 2);
    ack();
    do_eoi();

    // W1C racing a new rising edge
    wr(2'd0, 8'hEF);
    irq[4] = 1'b1;
    ticks(3);
    irq[4] = 1'b0;
    ticks(3);
    rd(2'd2, r);
    chk("w1c_pre", 32'(r), 32'h10);
    irq[4] = 1'b1;
    ticks(2);
    wr(2'd2, 8'h10);
    rd(2'd2, r);
    chk("w1c_race", 32'(r), 32'h10);
    wr(2'd2, 8'h10);
    rd(2'd2, r);
    chk("w1c_clr", 32'(r), 0);
    irq[4] = 1'b0;
    ticks(3);
    wr(2'd0, 8'hFF);

    // source arriving while id 6 is in service
    wr(2'd1, 8'h00);
    irq[6] = 1'b1;
    wait_int("svc_to6");
    chk("svc_id6", 32'(int_id), 6);
    ack();
    irq[6] = 1'b0;
    irq[1] = 1'b1;
    ticks(6);
`ifdef IRQ_CTRL_NESTED_INT_EN
    chk("nst_int", 32'(interrupt), 1);
    chk("nst_id", 32'(int_id), 1);
    ack();
    rd(2'd3, r);
    chk("nst_isr2", 32'(r), 32'h42);
    irq[1] = 1'b0;
    ticks(3);
    do_eoi();
    rd(2'd3, r);
    chk("nst_isr1", 32'(r), 32'h40);
    chk("nst_insvc", 32'(in_service), 1);
    do_eoi();
    rd(2'd3, r);
    chk("nst_isr0", 32'(r), 0);
`else
    chk("hold_int", 32'(interrupt), 0);
    rd(2'd3, r);
    chk("hold_isr", 32'(r), 32'h40);
    do_eoi();
    chk("hold_idle", 32'(interrupt), 0);
    tick();
    chk("hold_int2", 32'(interrupt), 1);
    chk("hold_id", 32'(int_id), 1);
    ack();
    irq[1] = 1'b0;
    ticks(3);
    do_eoi();
`endif
    ticks(2);

    // async reset while a request is pending
    irq[0] = 1'b1;
    wait_int("rst_to");
    #1;
    reset = 1'b0;
    #1;
    chk("arst_int", 32'(interrupt), 0);
    chk("arst_insvc", 32'(in_service), 0);
    rd(2'd3, r);
    chk("arst_isr", 32'(r), 0);
    rd(2'd0, r);
    chk("arst_en", 32'(r), 0);
    ticks(2);
    reset = 1'b1;
    tick();
    wr(2'd0, 8'hFF);
    wait_int("rerq_to");
    chk("rerq_id", 32'(int_id), 0);
    ack();
    irq[0] = 1'b0;
    ticks(3);
    do_eoi();
    ticks(2);

    // randomized level-mode deliveries
    for (int t = 0; t < 12; t++) begin
      m = 8'($urandom_range(1, 255));
      e = 8'($urandom);
      wr(2'd0, e);
      irq = m;
      exp_id = lowest(m & e);
      if (exp_id >= 0) begin
        wait_int($sformatf("rl%0d_to", t));
        chk($sformatf("rl%0d_id", t), 32'(int_id), 32'(exp_id));
        chk($sformatf("rl%0d_vec", t), int_vec, vec_of(exp_id));
        ack();
        rd(2'd3, r);
        chk($sformatf("rl%0d_isr", t), 32'(r), 32'(1) << exp_id);
        irq = '0;
        ticks(3);
        do_eoi();
        chk($sformatf("rl%0d_done", t), 32'(in_service), 0);
      end else begin
        ticks(6);
        chk($sformatf("rl%0d_none", t), 32'(interrupt), 0);
        irq = '0;
        ticks(3);
      end
      ticks(2);
    end

    // randomized edge-mode bursts served in priority order
    wr(2'd1, 8'hFF);
    wr(2'd0, 8'hFF);
    for (int t = 0; t < 4; t++) begin
      p = 8'($urandom_range(1, 255));
      q.delete();
      for (int i = 0; i < 8; i++) if (p[i]) q.push_back(i);
      irq = p;
      ticks(3);
      irq = '0;
      while (q.size() > 0) begin
        exp_id = q.pop_front();
        wait_int($sformatf("re%0d_to", t));
        chk($sformatf("re%0d_id", t), 32'(int_id), 32'(exp_id));
        ack();
        do_eoi();
      end
      ticks(2);
      rd(2'd2, r);
      chk($sformatf("re%0d_pend", t), 32'(r), 0);
      chk($sformatf("re%0d_int", t), 32'(interrupt), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_ctrl_nch.md
Name: irq_ctrl_nch

Overview:
- Parametrised N-channel interrupt controller for the Robonaut core.
- Replaces the single `interrupt` / `int_ack` source wired between CU64 and Core_Architecture.
- Synchronises, masks and prioritises NUM_IRQ sources and drives one `interrupt` request to CU64.
- Supplies the vector address and id of the winning source, and tracks in-service state until CU64 signals end-of-interrupt.

Parameters:
- NUM_IRQ, 8, number of interrupt sources (1..32); index 0 is highest priority.
- ID_W, 3, width of the source id; must be >= clog2(NUM_IRQ).
- VEC_BASE, 32'h0000_0100, vector address of source 0.
- VEC_STRIDE, 8, byte spacing between consecutive vectors.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- irq  in  NUM_IRQ  raw interrupt sources, asynchronous to clk.
- cfg_we  in  1  config register write strobe.
- cfg_addr  in  2  register select: 0 ENABLE, 1 EDGE, 2 PEND, 3 ISR.
- cfg_wdata  in  NUM_IRQ  config write data.
- cfg_rdata  out  NUM_IRQ  combinational read of the register at cfg_addr.
- interrupt  out  1  request to CU64.
- int_ack  in  1  one-cycle acknowledge from CU64.
- eoi  in  1  one-cycle end-of-interrupt from CU64.
- int_vec  out  32  vector address of the current/last delivered source.
- int_id  out  ID_W  id of the current/last delivered source.
- in_service  out  1  high while any ISR bit is set.

Behaviour:
- Reset (async, reset=0): ENABLE, EDGE, PEND, ISR, synchroniser flops = 0; interrupt=0; int_vec=VEC_BASE; int_id=0; in_service=0; FSM=IDLE.
- Synchroniser: every irq bit passes two flops; s_irq is the second stage.
- Edge mode (EDGE[i]=1):
  - A rising edge of s_irq[i] sets PEND[i].
  - Writing 1 to PEND[i] clears it (W1C).
  - A set and a clear in the same cycle: set wins.
- Level mode (EDGE[i]=0): PEND[i] = s_irq[i] each cycle; PEND writes are ignored.
- Registers: ENABLE and EDGE are read/write; ISR is read-only.
- Eligible = PEND & ENABLE & ~ISR. Winner = lowest set index of Eligible.
- FSM:
  - IDLE: if Eligible != 0, latch winner into int_id and set int_vec = VEC_BASE + id*VEC_STRIDE (32-bit, wraps mod 2^32); go REQ. interrupt rises on the cycle after eligibility.
  - REQ: hold interrupt=1 and freeze id/vec.
    - On int_ack: interrupt=0, set ISR[id], clear PEND[id] if in edge mode; go SERVICE.
    - If the source deasserts or is disabled while in REQ, delivery still completes.
  - SERVICE: no new request is raised.
    - On eoi: clear ISR[id], go IDLE.
    - Next request may issue 1 cycle after the return to IDLE.
- int_ack outside REQ and eoi outside SERVICE are ignored.
- int_ack and eoi in the same cycle: only the one matching the current state acts.
- Minimum latency: synchronised assertion to interrupt high = 1 cycle (2 more cycles for the synchroniser).
- Reset mid-operation returns every state to its reset value immediately; a request in flight is lost.

Optional Feature:
- Macro: IRQ_CTRL_NESTED_INT_EN.
- When defined:
  - In SERVICE, a source with index lower than the lowest set ISR bit that becomes eligible moves the FSM to REQ (preemption). Other sources are held off.
  - ISR can hold multiple bits.
  - eoi clears the lowest set ISR bit. The FSM returns to SERVICE if ISR is still non-zero, otherwise to IDLE.
  - int_id/int_vec show the newest delivery.
- When undefined: strictly one interrupt in service at a time, as described above.

Test Plan:
- Reset release, ENABLE=0xFF, EDGE=0x00, irq[3] held high -> interrupt=1 three cycles after assertion (two synchroniser cycles + one); int_id=3, int_vec=0x118; int_ack -> interrupt=0, ISR=0x08, in_service=1; eoi -> ISR=0, in_service=0.
- irq[5] and irq[2] rise in the same cycle, both edge mode -> int_id=2 first; after ack+eoi, int_id=5 with vec 0x128; PEND ends at 0.
- ENABLE=0xFB, irq[2] pulses in edge mode -> PEND[2]=1, no interrupt; write ENABLE=0xFF -> interrupt raised, id 2.
- Edge-mode PEND[4] set, then W1C write of 0x10 in the same cycle as a new rising edge on irq[4] -> PEND[4] stays 1.
- In SERVICE for id 6, irq[1] asserts -> without the macro, interrupt stays 0 until eoi; with IRQ_CTRL_NESTED_INT_EN, interrupt=1 and int_id=1; ISR=0x42 after ack; first eoi leaves ISR=0x40.
- reset driven low while in REQ -> interrupt=0 and ISR=0 immediately, without waiting for a clock edge; after release with irq[0] still high, the request is re-raised.
